// File: rtl/fifo_sync_buffer.sv
// Single-clock FIFO buffering words from the sync register for the consumer.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_sync_buffer #(
  parameter int SIZE  = 4,
  parameter int DEPTH = 8
) (
  input  logic                       r_clk,
  input  logic                       rst,
  input  logic [SIZE-1:0]            w_data,
  input  logic                       w_en,
  output logic                       w_full,
  input  logic                       r_en,
  output logic [SIZE-1:0]            r_data,
  output logic                       r_valid,
  output logic                       r_empty,
  output logic [$clog2(DEPTH):0]     count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                       overflow,
  output logic                       underflow
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  logic [SIZE-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              wr_acc, rd_acc;

  // When full, a concurrent read frees the slot the write lands in.
  assign rd_acc = r_en && !r_empty;
  assign wr_acc = w_en && (!w_full || rd_acc);

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (!rst && wr_acc) mem[wr_ptr] <= w_data;
  end

  always_ff @(posedge r_clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      r_empty <= 1'b1;
      w_full  <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        r_data <= mem[rd_ptr];
      end
      r_valid <= rd_acc;
      count   <= count_nxt;
      r_empty <= (count_nxt == '0);
      w_full  <= (count_nxt == FULL_CNT);
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge r_clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && w_full)  overflow  <= 1'b1;
      if (r_en && r_empty) underflow <= 1'b1;
    end
  end
`endif

endmodule
